// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: op encodings, instruction
// field layout, register index width and flag bit order.
package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 4;

    // ALU op encodings; the op field is passed straight to the ALU.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Instruction field bit positions.
    localparam int INSTR_OP_HI  = 31;
    localparam int INSTR_OP_LO  = 29;
    localparam int INSTR_IMM    = 28;
    localparam int INSTR_RD_HI  = 27;
    localparam int INSTR_RD_LO  = 24;
    localparam int INSTR_RS1_HI = 23;
    localparam int INSTR_RS1_LO = 20;
    localparam int INSTR_RS2_HI = 19;
    localparam int INSTR_RS2_LO = 16;
    localparam int INSTR_K_HI   = 15;
    localparam int INSTR_K_LO   = 0;

    // Bit order inside the 3-bit flags word.
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 0;

    typedef struct packed {
        logic [2:0]           op;
        logic                 imm;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [15:0]          k;
    } instr_t;

    // Split a raw instruction word into its fields.
    function automatic instr_t decode_instr(input logic [DATA_W-1:0] w);
        instr_t d;
        d.op  = w[INSTR_OP_HI:INSTR_OP_LO];
        d.imm = w[INSTR_IMM];
        d.rd  = w[INSTR_RD_HI:INSTR_RD_LO];
        d.rs1 = w[INSTR_RS1_HI:INSTR_RS1_LO];
        d.rs2 = w[INSTR_RS2_HI:INSTR_RS2_LO];
        d.k   = w[INSTR_K_HI:INSTR_K_LO];
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake, ALU operand/result bus and writeback bus of the
// issue stage. master = issue stage, slave = fetch/ALU/environment side.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_instr;

    logic [2:0]           alu_opcode;
    logic [DATA_W-1:0]    alu_operand1;
    logic [DATA_W-1:0]    alu_operand2;
    logic [DATA_W-1:0]    alu_result;
    logic                 alu_zero;
    logic                 alu_overflow;
    logic                 alu_carry;

    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [DATA_W-1:0]    wb_data;

    modport master (
        input  in_valid, in_instr,
        output in_ready,
        output alu_opcode, alu_operand1, alu_operand2,
        input  alu_result, alu_zero, alu_overflow, alu_carry,
        output wb_valid, wb_rd, wb_data
    );

    modport slave (
        output in_valid, in_instr,
        input  in_ready,
        input  alu_opcode, alu_operand1, alu_operand2,
        output alu_result, alu_zero, alu_overflow, alu_carry,
        input  wb_valid, wb_rd, wb_data
    );

endinterface

// File: rtl/alu_regfile.sv
// Register file: two async operand read ports, one async debug read port
// and one synchronous write port. r0 always reads zero and ignores writes.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_addr_i,
    output logic [DATA_W-1:0]    rs1_data_o,
    input  logic [REG_IDX_W-1:0] rs2_addr_i,
    output logic [DATA_W-1:0]    rs2_data_o,
    input  logic [REG_IDX_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0]    dbg_data_o,
    input  logic                 we_i,
    input  logic [REG_IDX_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]    wr_data_i
);

    logic [DATA_W-1:0] regs_q [NREGS];

    // Clear on reset; otherwise write the retiring result, dropping r0 writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wr_addr_i != '0)) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the external combinational ALU. Decodes in the
// accept cycle, registers opcode/operands into E, and retires the ALU result
// into the register file and flags on the following edge.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int               NREGS        = 16,
    parameter logic [DATA_W-1:0] RESET_PC_TAG = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    alu_issue_stage_if.master    bus,
    output logic [2:0]           flags,
    output logic [DATA_W-1:0]    retired,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);

    instr_t               dec;
    logic [DATA_W-1:0]    rf_rs1;
    logic [DATA_W-1:0]    rf_rs2;
    logic                 fwd_rs1;
    logic                 fwd_rs2;
    logic                 accept;
    logic                 retire;

    logic                 e_valid_q;
    logic [REG_IDX_W-1:0] e_rd_q;
    logic [2:0]           opcode_q;
    logic [DATA_W-1:0]    op1_q;
    logic [DATA_W-1:0]    op1_d;
    logic [DATA_W-1:0]    op2_q;
    logic [DATA_W-1:0]    op2_d;

    logic                 wb_valid_q;
    logic [REG_IDX_W-1:0] wb_rd_q;
    logic [DATA_W-1:0]    wb_data_q;
    logic [2:0]           flags_q;
    logic [2:0]           flags_d;
    logic [DATA_W-1:0]    retired_q;

    assign dec    = decode_instr(bus.in_instr);
    assign accept = bus.in_valid & ~stall;
    assign retire = e_valid_q & ~stall;

    alu_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr_i (dec.rs1),
        .rs1_data_o (rf_rs1),
        .rs2_addr_i (dec.rs2),
        .rs2_data_o (rf_rs2),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (retire),
        .wr_addr_i  (e_rd_q),
        .wr_data_i  (bus.alu_result)
    );

    // The E-stage result lands in the regfile on the same edge that captures
    // the next operands, so only the in-flight E result needs bypassing.
    assign fwd_rs1 = e_valid_q && (e_rd_q != '0) && (dec.rs1 == e_rd_q);
    assign fwd_rs2 = e_valid_q && (e_rd_q != '0) && (dec.rs2 == e_rd_q);

    // Decode: operand selection with bypass and zero-extended immediate.
    always_comb begin
        op1_d = fwd_rs1 ? bus.alu_result : rf_rs1;
        if (dec.imm) begin
            op2_d = {{(DATA_W-16){1'b0}}, dec.k};
        end else begin
            op2_d = fwd_rs2 ? bus.alu_result : rf_rs2;
        end
        flags_d             = '0;
        flags_d[FLAG_CARRY] = bus.alu_carry;
        flags_d[FLAG_OVF]   = bus.alu_overflow;
        flags_d[FLAG_ZERO]  = bus.alu_zero;
    end

    // Execute: load a new instruction or bubble unless stalled; alu_* only
    // change when a real instruction is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q <= 1'b0;
            e_rd_q    <= '0;
            opcode_q  <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
        end else if (!stall) begin
            e_valid_q <= bus.in_valid;
            if (accept) begin
                e_rd_q   <= dec.rd;
                opcode_q <= dec.op;
                op1_q    <= op1_d;
                op2_q    <= op2_d;
            end
        end
    end

    // Writeback: capture ALU result and flags for a valid, unstalled E entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            flags_q    <= '0;
            retired_q  <= RESET_PC_TAG;
        end else begin
            wb_valid_q <= retire;
            if (retire) begin
                wb_rd_q   <= e_rd_q;
                wb_data_q <= bus.alu_result;
                flags_q   <= flags_d;
                retired_q <= retired_q + {{(DATA_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.in_ready     = ~stall;
    assign bus.alu_opcode   = opcode_q;
    assign bus.alu_operand1 = op1_q;
    assign bus.alu_operand2 = op2_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign flags            = flags_q;
    assign retired          = retired_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: wires in a behavioural ALU, drives instruction
// sequences and scoreboards every writeback (rd, data, flags, cycle).
module tb_alu_issue_stage;
    import alu_pkg::*;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
        logic [2:0]  flg;
        logic [31:0] cyc;
    } wb_rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  flags;
    logic [31:0] retired;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] cyc = 0;

    int n_assert = 0;
    int n_fail   = 0;

    wb_rec_t     exp_q[$];
    wb_rec_t     obs_q[$];
    logic [31:0] mreg [16];
    logic [31:0] model_retired;

    alu_issue_stage_if bus_if();

    alu_issue_stage #(
        .NREGS        (16),
        .RESET_PC_TAG (32'd0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .bus      (bus_if),
        .flags    (flags),
        .retired  (retired),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: returns {carry, overflow, zero, result}.
    function automatic logic [34:0] alu_eval(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        o;
        c = 1'b0; o = 1'b0; r = '0; w = '0;
        case (op)
            OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; o = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_SUB: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32]; o = (a[31] != b[31]) && (r[31] != a[31]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SHL: r = a << b[4:0];
            default: r = a >> b[4:0];
        endcase
        return {c, o, (r == 32'd0), r};
    endfunction

    logic [34:0] alu_out;
    always_comb begin
        alu_out             = alu_eval(bus_if.alu_opcode, bus_if.alu_operand1, bus_if.alu_operand2);
        bus_if.alu_result   = alu_out[31:0];
        bus_if.alu_carry    = alu_out[34];
        bus_if.alu_overflow = alu_out[33];
        bus_if.alu_zero     = alu_out[32];
    end

    // Record every writeback pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_if.wb_valid === 1'b1)
            obs_q.push_back('{rd: bus_if.wb_rd, data: bus_if.wb_data, flg: flags, cyc: cyc});
    end

    function automatic logic [31:0] enc(input logic [2:0] op, input logic imm, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2, input logic [15:0] k);
        return {op, imm, rd, rs1, rs2, k};
    endfunction

    // Architectural model: sequential execution, expected writeback queued.
    task automatic model_push(input logic [31:0] w, input int extra);
        instr_t      d;
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] r;
        d = decode_instr(w);
        a = (d.rs1 == 4'd0) ? 32'd0 : mreg[d.rs1];
        b = d.imm ? {16'h0, d.k} : ((d.rs2 == 4'd0) ? 32'd0 : mreg[d.rs2]);
        r = alu_eval(d.op, a, b);
        if (d.rd != 4'd0) mreg[d.rd] = r[31:0];
        model_retired = model_retired + 32'd1;
        exp_q.push_back('{rd: d.rd, data: r[31:0], flg: r[34:32], cyc: cyc + 32'd2 + 32'(extra)});
    endtask

    // Present one instruction for one cycle (called at posedge+1).
    task automatic issue(input logic [31:0] w, input bit expect_wb, input int extra);
        if (expect_wb) model_push(w, extra);
        bus_if.in_valid = 1'b1;
        bus_if.in_instr = w;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Bounded wait until n writebacks have been observed, then settle.
    task automatic wait_obs(input int n);
        for (int k = 0; k < 40; k++) begin
            if (obs_q.size() >= n) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; bus_if.in_valid = 1'b0; bus_if.in_instr = '0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_assert++; if (bus_if.wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got=%b want=0", bus_if.wb_valid); end
        n_assert++; if (bus_if.alu_opcode !== 3'd0) begin n_fail++; $display("FAIL reset_opcode got=%0d want=0", bus_if.alu_opcode); end
        n_assert++; if ({bus_if.alu_operand1, bus_if.alu_operand2} !== 64'd0) begin n_fail++; $display("FAIL reset_operands got=%h/%h want=0/0", bus_if.alu_operand1, bus_if.alu_operand2); end
        n_assert++; if ({bus_if.wb_rd, bus_if.wb_data, flags} !== 39'd0) begin n_fail++; $display("FAIL reset_wb_fields got rd=%0d data=%h flags=%b want 0", bus_if.wb_rd, bus_if.wb_data, flags); end
        n_assert++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got=%0d want=0", retired); end
        n_assert++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", bus_if.in_ready); end
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        model_retired = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        wb_rec_t e;
        wb_rec_t o;
        @(posedge clk); #1;
        issue(enc(OP_ADD, 1'b1, 4'd1, 4'd0, 4'd0, 16'd5), 1'b1, 0);
        issue(enc(OP_ADD, 1'b1, 4'd2, 4'd0, 4'd0, 16'd7), 1'b1, 0);
        issue(enc(OP_ADD, 1'b0, 4'd3, 4'd1, 4'd2, 16'd0), 1'b1, 0);
        wait_obs(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_assert++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL basic_missing_wb want rd=%0d data=%h", e.rd, e.data); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL basic_wb got rd=%0d data=%h flags=%b cyc=%0d want rd=%0d data=%h flags=%b cyc=%0d", o.rd, o.data, o.flg, o.cyc, e.rd, e.data, e.flg, e.cyc); end end
        end
        n_assert++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL basic_extra_wb got=%0d want=0", obs_q.size()); obs_q.delete(); end
        n_assert++; if (retired !== model_retired) begin n_fail++; $display("FAIL basic_retired got=%0d want=%0d", retired, model_retired); end
        n_assert++; if (flags !== 3'b000) begin n_fail++; $display("FAIL basic_flags got=%b want=000", flags); end
        dbg_addr = 4'd3; #1;
        n_assert++; if (dbg_data !== 32'd12) begin n_fail++; $display("FAIL basic_dbg_r3 got=%0d want=12", dbg_data); end
    endtask

    task automatic test_back_to_back();
        wb_rec_t e;
        wb_rec_t o;
        @(posedge clk); #1;
        issue(enc(OP_ADD, 1'b1, 4'd1, 4'd0, 4'd0, 16'd1), 1'b1, 0);
        issue(enc(OP_ADD, 1'b0, 4'd1, 4'd1, 4'd1, 16'd0), 1'b1, 0);
        issue(enc(OP_ADD, 1'b0, 4'd4, 4'd2, 4'd1, 16'd0), 1'b1, 0);
        issue(enc(OP_SHL, 1'b1, 4'd5, 4'd4, 4'd0, 16'd3), 1'b1, 0);
        issue(enc(OP_ADD, 1'b1, 4'd6, 4'd0, 4'd0, 16'h8000), 1'b1, 0);
        wait_obs(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_assert++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_missing_wb want rd=%0d data=%h", e.rd, e.data); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL b2b_wb got rd=%0d data=%h flags=%b cyc=%0d want rd=%0d data=%h flags=%b cyc=%0d", o.rd, o.data, o.flg, o.cyc, e.rd, e.data, e.flg, e.cyc); end end
        end
        n_assert++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra_wb got=%0d want=0", obs_q.size()); obs_q.delete(); end
        dbg_addr = 4'd1; #1;
        n_assert++; if (dbg_data !== 32'd2) begin n_fail++; $display("FAIL b2b_dbg_r1 got=%0d want=2", dbg_data); end
    endtask

    task automatic test_ops();
        wb_rec_t e;
        wb_rec_t o;
        logic [2:0] ops [6];
        ops = '{OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHR, OP_SUB};
        @(posedge clk); #1;
        issue(enc(OP_ADD, 1'b1, 4'd8, 4'd0, 4'd0, 16'($urandom_range(1, 16'hffff))), 1'b1, 0);
        issue(enc(OP_ADD, 1'b1, 4'd9, 4'd0, 4'd0, 16'($urandom_range(1, 16'hffff))), 1'b1, 0);
        for (int i = 0; i < 6; i++)
            issue(enc(ops[i], 1'b0, 4'(10 + i), 4'd8, 4'd9, 16'd0), 1'b1, 0);
        wait_obs(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_assert++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL ops_missing_wb want rd=%0d data=%h", e.rd, e.data); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL ops_wb got rd=%0d data=%h flags=%b cyc=%0d want rd=%0d data=%h flags=%b cyc=%0d", o.rd, o.data, o.flg, o.cyc, e.rd, e.data, e.flg, e.cyc); end end
        end
        n_assert++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL ops_extra_wb got=%0d want=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_sub_zero();
        wb_rec_t e;
        wb_rec_t o;
        @(posedge clk); #1;
        issue(enc(OP_ADD, 1'b1, 4'd1, 4'd0, 4'd0, 16'd9), 1'b1, 0);
        issue(enc(OP_SUB, 1'b0, 4'd4, 4'd1, 4'd1, 16'd0), 1'b1, 0);
        wait_obs(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_assert++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL sub_missing_wb want rd=%0d data=%h", e.rd, e.data); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL sub_wb got rd=%0d data=%h flags=%b cyc=%0d want rd=%0d data=%h flags=%b cyc=%0d", o.rd, o.data, o.flg, o.cyc, e.rd, e.data, e.flg, e.cyc); end end
        end
        n_assert++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL sub_extra_wb got=%0d want=0", obs_q.size()); obs_q.delete(); end
        n_assert++; if (flags[FLAG_ZERO] !== 1'b1) begin n_fail++; $display("FAIL sub_zero_flag got=%b want=1", flags[FLAG_ZERO]); end
    endtask

    task automatic test_r0_write();
        wb_rec_t e;
        wb_rec_t o;
        @(posedge clk); #1;
        issue(enc(OP_ADD, 1'b1, 4'd0, 4'd0, 4'd0, 16'd3), 1'b1, 0);
        issue(enc(OP_ADD, 1'b0, 4'd7, 4'd0, 4'd0, 16'd0), 1'b1, 0);
        wait_obs(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_assert++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL r0_missing_wb want rd=%0d data=%h", e.rd, e.data); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL r0_wb got rd=%0d data=%h flags=%b cyc=%0d want rd=%0d data=%h flags=%b cyc=%0d", o.rd, o.data, o.flg, o.cyc, e.rd, e.data, e.flg, e.cyc); end end
        end
        n_assert++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL r0_extra_wb got=%0d want=0", obs_q.size()); obs_q.delete(); end
        dbg_addr = 4'd0; #1;
        n_assert++; if (dbg_data !== 32'd0) begin n_fail++; $display("FAIL r0_dbg got=%h want=0", dbg_data); end
    endtask

    task automatic test_stall();
        wb_rec_t     e;
        wb_rec_t     o;
        logic [31:0] ret0;
        @(posedge clk); #1;
        ret0 = model_retired;
        issue(enc(OP_ADD, 1'b1, 4'd7, 4'd0, 4'd0, 16'd42), 1'b1, 3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_assert++; if ({bus_if.alu_opcode, bus_if.alu_operand1, bus_if.alu_operand2} !== {OP_ADD, 32'd0, 32'd42}) begin
                n_fail++; $display("FAIL stall_alu_hold cycle=%0d got op=%0d a=%h b=%h want op=0 a=0 b=2a", i, bus_if.alu_opcode, bus_if.alu_operand1, bus_if.alu_operand2); end
            n_assert++; if ({bus_if.wb_valid, bus_if.in_ready} !== 2'b00) begin
                n_fail++; $display("FAIL stall_wb_ready cycle=%0d got wb_valid=%b in_ready=%b want 0 0", i, bus_if.wb_valid, bus_if.in_ready); end
            n_assert++; if (retired !== ret0) begin n_fail++; $display("FAIL stall_retired cycle=%0d got=%0d want=%0d", i, retired, ret0); end
        end
        @(posedge clk); #1;
        stall = 1'b0;
        wait_obs(1);
        repeat (3) @(negedge clk);
        n_assert++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL stall_release_count got=%0d want=1", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_assert++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL stall_missing_wb want rd=%0d data=%h", e.rd, e.data); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL stall_wb got rd=%0d data=%h flags=%b cyc=%0d want rd=%0d data=%h flags=%b cyc=%0d", o.rd, o.data, o.flg, o.cyc, e.rd, e.data, e.flg, e.cyc); end end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        issue(enc(OP_ADD, 1'b1, 4'd5, 4'd0, 4'd0, 16'd9), 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        model_retired = 32'd0;
        @(negedge clk);
        n_assert++; if (bus_if.wb_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_wb_valid got=%b want=0", bus_if.wb_valid); end
        n_assert++; if ({bus_if.alu_opcode, bus_if.alu_operand1, bus_if.alu_operand2} !== 67'd0) begin n_fail++; $display("FAIL rstmid_alu got op=%0d a=%h b=%h want 0", bus_if.alu_opcode, bus_if.alu_operand1, bus_if.alu_operand2); end
        n_assert++; if ({bus_if.wb_rd, bus_if.wb_data, flags} !== 39'd0) begin n_fail++; $display("FAIL rstmid_wb_fields got rd=%0d data=%h flags=%b want 0", bus_if.wb_rd, bus_if.wb_data, flags); end
        n_assert++; if (retired !== model_retired) begin n_fail++; $display("FAIL rstmid_retired got=%0d want=%0d", retired, model_retired); end
        dbg_addr = 4'd5; #1;
        n_assert++; if (dbg_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_dbg_r5 got=%h want=0", dbg_data); end
        repeat (4) @(negedge clk);
        n_assert++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_wb_seen got=%0d want=0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ops();
        test_sub_zero();
        test_r0_write();
        test_stall();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the combinational 32-bit ALU: accepts 32-bit instructions over a valid/ready handshake and decodes them.
- Reads operands from an internal 16x32 register file and drives registered opcode/operand1/operand2 into the ALU.
- Captures the ALU's result and flags on the following edge and writes them back to the register file and a flags register.
- Sits between instruction fetch and the ALU in the RISC core.

Parameters:
- NREGS, 16, register-file depth (index width = 4; fixed for this revision).
- RESET_PC_TAG, 0, initial value of the retired-instruction counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready.
- in_instr  in  32  instruction word.
- stall  in  1  downstream freeze.
- alu_opcode  out  3  registered ALU op.
- alu_operand1  out  32  registered operand 1.
- alu_operand2  out  32  registered operand 2.
- alu_result  in  32  ALU result, combinational from alu_* outputs.
- alu_zero / alu_overflow / alu_carry  in  1 each  ALU flags.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_rd  out  4  destination register of the retired instruction.
- wb_data  out  32  value written back.
- flags  out  3  {carry, overflow, zero} of the last retired instruction.
- retired  out  32  count of retired instructions.
- dbg_addr  in  4  debug read index.
- dbg_data  out  32  combinational register-file read; r0 reads 0.

Behaviour:
- Clocking and reset: one clock domain, clk; reset is rst, synchronous, active-high.
- Reset values: E-stage valid=0; alu_opcode=0; alu_operand1/2=0; wb_valid=0; wb_rd=0; wb_data=0; flags=0; retired=RESET_PC_TAG; all registers=0.
- Reset mid-operation discards any in-flight instruction with no writeback.
- Instruction format:
  - [31:29] op.
  - [28] imm: 1 selects zero-extended [15:0] as operand2.
  - [27:24] rd, [23:20] rs1, [19:16] rs2.
- Op encoding: ADD 000, SUB 001, AND 010, OR 011, XOR 100, NOT 101, SHL 110, SHR 111. Op passes straight to alu_opcode.
- r0 is hardwired zero: reads return 0 and writes are dropped. The writeback still pulses wb_valid with wb_rd=0, and flags still update.
- Pipeline:
  - Decode (D): combinational, in the accept cycle.
  - Execute (E): alu_* registered at the accept edge N; ALU evaluates during cycle N+1.
  - Writeback (W): at edge N+1, if E is valid and stall=0:
    - regfile[rd] <= alu_result;
    - flags <= {alu_carry, alu_overflow, alu_zero};
    - wb_valid <= 1, wb_rd <= rd, wb_data <= alu_result;
    - retired <= retired+1, wrapping 2^32-1 -> 0.
  - Otherwise wb_valid <= 0.
- Latency: accept at edge N -> wb_valid high in cycle N+2. Throughput is 1 instruction/cycle.
- Forwarding: if E is valid, E.rd != 0, and a decoding rs1 or rs2 equals E.rd, the operand is alu_result (combinational bypass) instead of the regfile value. A W-stage forward is not needed because the regfile write and E capture share the same edge.
- dbg_data reads the regfile without bypass.
- in_ready = ~stall.
- While stall=1:
  - E holds and alu_* are stable.
  - No writeback; wb_valid=0 and retired holds.
  - No accept.
- When stall deasserts, the held E instruction retires at the next edge.
- Acceptance with in_valid=0 (stall=0) loads a bubble: E valid=0, alu_* hold their last values, and the next cycle has no writeback.
- A simultaneous accept and W-stage retire at the same edge is normal operation; both happen.

Decomposition:
- Shared package alu_pkg:
  - localparams for the 3-bit op encodings (OP_ADD..OP_SHR);
  - instruction field bit positions;
  - REG_IDX_W=4;
  - flag bit order CARRY=2, OVF=1, ZERO=0.
- One sub-module: alu_regfile. It has 2 async read ports, 1 debug read port and 1 sync write port, with r0 forced to zero.
- The ALU itself stays external, and the top-level test harness wires it in.

Test Plan:
- Reset, then the following instructions with stall=0 and real ALU attached:
  - ADDI r1,r0,#5;
  - ADDI r2,r0,#7;
  - ADD r3,r1,r2.
  - Required: wb pulses at cycles 2,3,4 with (1,5),(2,7),(3,12); retired=3; flags=000.
- Back-to-back dependency: ADDI r1,r0,#1 then ADD r1,r1,r1 on consecutive cycles -> second writeback is 2 (forwarded, not stale 0).
- SUB r4,r1,r1 with r1=9 -> wb_data=0 and flags[0]=1.
- Write to r0 with ADDI r0,r0,#3 -> wb_valid pulses with wb_rd=0, and dbg_data at addr 0 reads 0.
- Stall held for 3 cycles with an instruction in E:
  - alu_* stable, no wb_valid, retired unchanged, in_ready=0;
  - after release, exactly one writeback.
- Assert rst the cycle after accepting ADDI r5,r0,#9 -> no writeback, dbg r5=0, retired=0, all outputs at reset values.
